// File: rtl/otter_bus_pkg.sv
// otter_bus_pkg: shared types, defaults and helpers for the OTTER data-side bus fabric.
package otter_bus_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_IO_WAIT = 2'd1, ST_RESP = 2'd2} state_t;
    typedef enum logic [1:0] {TGT_DMEM = 2'd0, TGT_IO = 2'd1, TGT_UNMAPPED = 2'd2} target_t;
    localparam logic [31:0] IO_BASE_DEF = 32'h1100_0000;
    localparam int DMEM_ADDR_EXP_DEF = 14;
    localparam int IO_CHANNELS_DEF = 4;
    localparam int IO_WIN_EXP_DEF = 8;
    localparam int TIMEOUT_CYC_DEF = 16;
    function automatic int ch_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic logic [31:0] strb_mask(input logic [31:0] d, input logic [3:0] s);
        return d & {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction
endpackage

// File: rtl/otter_bus_decode.sv
// otter_bus_decode: combinational address decode to DMEM / IO channel / unmapped.
module otter_bus_decode
    import otter_bus_pkg::*;
#(
    parameter int DMEM_ADDR_EXP = DMEM_ADDR_EXP_DEF,
    parameter logic [31:0] IO_BASE = IO_BASE_DEF,
    parameter int IO_CHANNELS = IO_CHANNELS_DEF,
    parameter int IO_WIN_EXP = IO_WIN_EXP_DEF,
    parameter int CH_W = ch_width(IO_CHANNELS)
) (
    input  logic [31:0]     addr,
    output target_t         target,
    output logic [CH_W-1:0] ch
);
    localparam logic [32:0] IO_END = {1'b0, IO_BASE} + (33'(IO_CHANNELS) << IO_WIN_EXP);
    logic dmem_hit, io_hit;
    always_comb begin
        dmem_hit = addr[31:DMEM_ADDR_EXP+2] == '0;
        io_hit = addr >= IO_BASE && {1'b0, addr} < IO_END;
        target = dmem_hit ? TGT_DMEM : io_hit ? TGT_IO : TGT_UNMAPPED;
        ch = CH_W'((addr - IO_BASE) >> IO_WIN_EXP);
    end
endmodule

// File: rtl/otter_mem_bus.sv
// otter_mem_bus: data RAM plus handshaked multi-channel MMIO window for the OTTER hart.
// Define OTTER_BUS_TIMEOUT_EN to bound IO wait states by TIMEOUT_CYC cycles.
module otter_mem_bus
    import otter_bus_pkg::*;
#(
    parameter int DMEM_ADDR_EXP = DMEM_ADDR_EXP_DEF,
    parameter logic [31:0] IO_BASE = IO_BASE_DEF,
    parameter int IO_CHANNELS = IO_CHANNELS_DEF,
    parameter int IO_WIN_EXP = IO_WIN_EXP_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    input  logic                      req_we,
    input  logic [3:0]                req_strb,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      req_ready,
    output logic                      rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic [IO_CHANNELS-1:0]    io_valid,
    output logic                      io_we,
    output logic [IO_WIN_EXP-1:0]     io_addr,
    output logic [31:0]               io_wdata,
    output logic [3:0]                io_strb,
    input  logic [IO_CHANNELS-1:0]    io_ready,
    input  logic [32*IO_CHANNELS-1:0] io_rdata
);
    localparam int CH_W = ch_width(IO_CHANNELS);
    state_t state, state_d;
    target_t tgt;
    logic [CH_W-1:0] ch, ch_q;
    logic [31:0] rdata_q;
    logic err_q, accept, io_done, io_to;
    logic [DMEM_ADDR_EXP-1:0] idx;
    logic [31:0] dmem [2**DMEM_ADDR_EXP];

    otter_bus_decode #(
        .DMEM_ADDR_EXP(DMEM_ADDR_EXP),
        .IO_BASE(IO_BASE),
        .IO_CHANNELS(IO_CHANNELS),
        .IO_WIN_EXP(IO_WIN_EXP),
        .CH_W(CH_W)
    ) u_decode (
        .addr(req_addr),
        .target(tgt),
        .ch(ch)
    );

    always_comb begin
        idx = req_addr[DMEM_ADDR_EXP+1:2];
        accept = state == ST_IDLE && req_valid;
        io_done = state == ST_IO_WAIT && io_ready[ch_q];
        req_ready = state == ST_IDLE;
        rsp_valid = state == ST_RESP;
        rsp_rdata = rsp_valid ? rdata_q : '0;
        rsp_err = rsp_valid & err_q;
        io_valid = state == ST_IO_WAIT ? IO_CHANNELS'(1) << ch_q : '0;
        state_d = state == ST_IDLE ? (req_valid ? (tgt == TGT_IO ? ST_IO_WAIT : ST_RESP) : ST_IDLE)
                : state == ST_IO_WAIT ? ((io_done || io_to) ? ST_RESP : ST_IO_WAIT)
                : ST_IDLE;
    end

`ifdef OTTER_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wait_cnt;
    // A ready on the limit edge takes priority, so the timeout is masked by io_done.
    assign io_to = state == ST_IO_WAIT && !io_done && wait_cnt == TW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= '0;
        else wait_cnt <= (state == ST_IO_WAIT && !io_done && !io_to) ? wait_cnt + 1'b1 : '0;
    end
`else
    assign io_to = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_n && accept && tgt == TGT_DMEM && req_we)
            for (int b = 0; b < 4; b++)
                if (req_strb[b]) dmem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            rdata_q <= '0;
            err_q <= 1'b0;
            ch_q <= '0;
            io_we <= 1'b0;
            io_addr <= '0;
            io_wdata <= '0;
            io_strb <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                err_q <= tgt == TGT_UNMAPPED;
                rdata_q <= (tgt == TGT_DMEM && !req_we) ? dmem[idx] : '0;
                if (tgt == TGT_IO) begin
                    ch_q <= ch;
                    io_we <= req_we;
                    io_addr <= req_addr[IO_WIN_EXP-1:0];
                    io_strb <= req_strb;
                    io_wdata <= strb_mask(req_wdata, req_strb);
                end
            end else if (io_done) begin
                rdata_q <= io_we ? '0 : io_rdata[32*ch_q +: 32];
            end else if (io_to) begin
                err_q <= 1'b1;
                rdata_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_otter_mem_bus.sv
// tb_otter_mem_bus: directed vector table, reset/timeout sequences and randomized model check.
module tb_otter_mem_bus;
    localparam logic [31:0] BASE = 32'h1100_0000;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0, req_we = 1'b0;
    logic [3:0] req_strb = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic req_ready, rsp_valid, rsp_err, io_we;
    logic [31:0] rsp_rdata, io_wdata;
    logic [NCH-1:0] io_valid;
    logic [7:0] io_addr;
    logic [3:0] io_strb;
    logic [NCH-1:0] io_ready = '0;
    logic [32*NCH-1:0] io_rdata = '0;

    otter_mem_bus dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_strb(req_strb),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .io_valid(io_valid), .io_we(io_we), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_strb(io_strb),
        .io_ready(io_ready), .io_rdata(io_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] chdata;
        int          exp_ch;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    int checks = 0, errors = 0;
    string cur = "reset";
    logic [31:0] mem [16384];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", cur, nm, act, exp);
        end
    endtask

    task automatic do_req(input vec_t v);
        logic [31:0] ew;
        int lat;
        bit done;
        cur = v.name;
        for (int b = 0; b < 4; b++) ew[8*b +: 8] = v.strb[b] ? v.wdata[8*b +: 8] : 8'h00;
        @(negedge clk);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = v.we; req_strb = v.strb; req_addr = v.addr; req_wdata = v.wdata;
        for (int k = 0; k < NCH; k++) io_rdata[32*k +: 32] = (k == v.exp_ch) ? v.chdata : $urandom;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = $urandom; req_strb = 4'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0;
        done = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                done = 1;
                io_ready = '0;
                check("latency", lat, v.exp_lat);
                check("rsp_rdata", rsp_rdata, v.exp_rdata);
                check("rsp_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
                check("io_valid_at_rsp", {28'b0, io_valid}, 32'd0);
            end else begin
                check("req_ready_busy", {31'b0, req_ready}, 32'd0);
                if (v.exp_ch >= 0) begin
                    check("io_valid", {28'b0, io_valid}, 32'(1) << v.exp_ch);
                    check("io_addr", {24'b0, io_addr}, {24'b0, v.addr[7:0]});
                    check("io_we", {31'b0, io_we}, {31'b0, v.we});
                    check("io_strb", {28'b0, io_strb}, {28'b0, v.strb});
                    check("io_wdata", io_wdata, ew);
                    io_ready = (4'($urandom) & ~(4'(1) << v.exp_ch)) |
                               ((lat == v.delay + 1) ? 4'(1) << v.exp_ch : 4'b0);
                end else begin
                    check("io_valid_none", {28'b0, io_valid}, 32'd0);
                end
            end
        end
        io_ready = '0;
        if (!done) check("rsp_never_came", 32'd0, 32'd1);
        @(negedge clk);
        check("rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);
        check("req_ready_after", {31'b0, req_ready}, 32'd1);
    endtask

    vec_t tv[14];
    vec_t v;
    int pool[17];

    initial begin
        tv[0]  = '{"dmem_clear",     1'b1, 4'hF, 32'h0000_0040, 32'h0000_0000, 0, 32'h0, -1, 32'h0,         1'b0, 1};
        tv[1]  = '{"dmem_wr_strb",   1'b1, 4'h5, 32'h0000_0040, 32'hDEAD_BEEF, 0, 32'h0, -1, 32'h0,         1'b0, 1};
        tv[2]  = '{"dmem_rd",        1'b0, 4'hF, 32'h0000_0040, 32'h0000_0000, 0, 32'h0, -1, 32'h00AD_00EF, 1'b0, 1};
        tv[3]  = '{"io_rd_ch1",      1'b0, 4'hF, 32'h1100_0104, 32'h0000_0000, 3, 32'h1234_5678, 1, 32'h1234_5678, 1'b0, 5};
        tv[4]  = '{"io_wr_ch0",      1'b1, 4'h8, 32'h1100_0000, 32'hAABB_CCDD, 0, 32'h5555_5555, 0, 32'h0,  1'b0, 2};
        tv[5]  = '{"unmapped_rd",    1'b0, 4'hF, 32'h2000_0000, 32'h0000_0000, 0, 32'h0, -1, 32'h0,         1'b1, 1};
        tv[6]  = '{"unmapped_wr",    1'b1, 4'hF, 32'h2000_0040, 32'hFFFF_FFFF, 0, 32'h0, -1, 32'h0,         1'b1, 1};
        tv[7]  = '{"past_io_win",    1'b0, 4'hF, 32'h1100_0400, 32'h0000_0000, 0, 32'h0, -1, 32'h0,         1'b1, 1};
        tv[8]  = '{"below_io_win",   1'b0, 4'hF, 32'h10FF_FFFC, 32'h0000_0000, 0, 32'h0, -1, 32'h0,         1'b1, 1};
        tv[9]  = '{"dmem_top_wr",    1'b1, 4'hF, 32'h0000_FFFC, 32'hCAFE_F00D, 0, 32'h0, -1, 32'h0,         1'b0, 1};
        tv[10] = '{"dmem_top_rd",    1'b0, 4'hF, 32'h0000_FFFC, 32'h0000_0000, 0, 32'h0, -1, 32'hCAFE_F00D, 1'b0, 1};
        tv[11] = '{"above_dmem",     1'b0, 4'hF, 32'h0001_0000, 32'h0000_0000, 0, 32'h0, -1, 32'h0,         1'b1, 1};
        tv[12] = '{"io_last_ch",     1'b0, 4'hF, 32'h1100_03FC, 32'h0000_0000, 0, 32'h0BAD_F00D, 3, 32'h0BAD_F00D, 1'b0, 2};
        tv[13] = '{"dmem_untouched", 1'b0, 4'hF, 32'h0000_0040, 32'h0000_0000, 0, 32'h0, -1, 32'h00AD_00EF, 1'b0, 1};

        repeat (2) @(negedge clk);
        check("req_ready", {31'b0, req_ready}, 32'd1);
        check("rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rsp_rdata", rsp_rdata, 32'd0);
        check("io_valid", {28'b0, io_valid}, 32'd0);
        check("io_addr", {24'b0, io_addr}, 32'd0);
        check("io_wdata", io_wdata, 32'd0);
        check("io_strb_we", {27'b0, io_strb, io_we}, 32'd0);
        rst_n = 1'b1;

        foreach (tv[i]) do_req(tv[i]);

        // reset while waiting on an IO channel
        cur = "rst_in_io_wait";
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_strb = 4'hF; req_addr = 32'h1100_0104;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("io_valid_before", {28'b0, io_valid}, 32'h2);
        rst_n = 1'b0;
        #1;
        check("io_valid_in_rst", {28'b0, io_valid}, 32'd0);
        check("rsp_valid_in_rst", {31'b0, rsp_valid}, 32'd0);
        check("req_ready_in_rst", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_rsp_after_rst", {31'b0, rsp_valid}, 32'd0);
            check("no_io_after_rst", {28'b0, io_valid}, 32'd0);
            check("ready_after_rst", {31'b0, req_ready}, 32'd1);
        end

        // reset in the response cycle of a DMEM write keeps the write
        cur = "rst_in_resp";
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_strb = 4'hF; req_addr = 32'h0000_0044; req_wdata = 32'h1122_3344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("rsp_valid_killed", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{"dmem_kept_write", 1'b0, 4'hF, 32'h0000_0044, 32'h0, 0, 32'h0, -1, 32'h1122_3344, 1'b0, 1};
        do_req(v);

`ifdef OTTER_BUS_TIMEOUT_EN
        v = '{"timeout_ch2", 1'b0, 4'hF, 32'h1100_0208, 32'h0, 1000, 32'h55AA_55AA, 2, 32'h0, 1'b1, 17};
        do_req(v);
        v = '{"ready_at_limit", 1'b0, 4'hF, 32'h1100_0208, 32'h0, 15, 32'h55AA_55AA, 2, 32'h55AA_55AA, 1'b0, 17};
        do_req(v);
`endif

        for (int i = 0; i < 16; i++) pool[i] = i;
        pool[16] = 16383;
        foreach (pool[i]) begin
            v = '{"rand_init", 1'b1, 4'hF, 32'(pool[i]) << 2, $urandom, 0, 32'h0, -1, 32'h0, 1'b0, 1};
            mem[pool[i]] = v.wdata;
            do_req(v);
        end
        for (int n = 0; n < 250; n++) begin
            int kind, ch, w;
            kind = $urandom_range(0, 2);
            v = '{"rand", 1'($urandom), 4'($urandom), 32'h0, $urandom, 0, 32'h0, -1, 32'h0, 1'b0, 1};
            if (kind == 0) begin
                v.name = "rand_dmem";
                w = pool[$urandom_range(0, 16)];
                v.addr = (32'(w) << 2) | 32'($urandom_range(0, 3));
                v.exp_rdata = v.we ? 32'h0 : mem[w];
                if (v.we)
                    for (int b = 0; b < 4; b++)
                        if (v.strb[b]) mem[w][8*b +: 8] = v.wdata[8*b +: 8];
            end else if (kind == 1) begin
                v.name = "rand_io";
                ch = $urandom_range(0, NCH - 1);
                v.addr = BASE + 32'(ch * 256) + 32'($urandom_range(0, 255));
                v.exp_ch = ch;
                v.delay = $urandom_range(0, 4);
                v.chdata = $urandom;
                v.exp_rdata = v.we ? 32'h0 : v.chdata;
                v.exp_lat = v.delay + 2;
            end else begin
                v.name = "rand_unmapped";
                v.addr = $urandom_range(0, 1) ? 32'h0001_0000 + $urandom_range(0, 32'h10FE_FFFF)
                                              : 32'h1100_0400 + $urandom_range(0, 32'hEEFF_FBFF);
                v.exp_err = 1'b1;
            end
            do_req(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
